// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared constants and helpers for the pipeline hazard controller:
//   - forwarding select encodings (FWD_RF / FWD_W / FWD_M)
//   - memory handshake FSM state encodings (MEM_IDLE / MEM_WAIT)
//   - reg_hit(): "later stage writes the register this source reads"
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from Writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from Memory-stage ALU result

  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  // x0 is hard-wired to zero, so a write to it never produces a hazard.
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Combinational forwarding select for one ALU operand. The Memory stage holds
// the younger result, so it takes priority over Writeback.
// Ports:
//   rs_e         in  5  source register of the Execute instruction
//   reg_write_m  in  1  Memory-stage register write enable
//   rd_m         in  5  Memory-stage destination register
//   reg_write_w  in  1  Writeback-stage register write enable
//   rd_w         in  5  Writeback-stage destination register
//   fwd_sel      out 2  FWD_RF / FWD_W / FWD_M
// ---------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic       reg_write_m,
  input  logic [4:0] rd_m,
  input  logic       reg_write_w,
  input  logic [4:0] rd_w,
  output logic [1:0] fwd_sel
);

  // Priority select: Memory beats Writeback beats register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_hit(reg_write_m, rd_m, rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_hit(reg_write_w, rd_w, rs_e)) begin
      fwd_sel = FWD_W;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RISC-V pipeline:
// load-use stall, branch flush, operand forwarding, a data-memory handshake
// FSM that freezes the pipeline while memory is busy, and a wait watchdog.
//
// Parameters:
//   MEM_TIMEOUT  WAIT cycles before the access is aborted (0 = no watchdog)
//   PERF_W       performance counter width (HAZARD_PERF_EN builds only)
// Optional feature macro: HAZARD_PERF_EN adds saturating perf counters
//   perf_lw_stalls, perf_flushes, perf_mem_wait.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   Rs1D, Rs2D               Decode sources
//   Rs1E, Rs2E, RdE          Execute sources / destination
//   ResultSrcE0              Execute instruction is a load
//   PCSrcE                   taken branch/jump resolved in Execute
//   RegWriteM, rdM           Memory-stage write enable / destination
//   RegWriteW, rdW           Writeback-stage write enable / destination
//   MemReqM, dmem_ready      data-memory request / completion
//   dmem_valid               request valid to data memory
//   StallF/D/E/M             pipeline register holds
//   FlushD/E/W               pipeline register clears (W = bubble into M/W)
//   ForwardAE, ForwardBE     ALU operand selects
//   mem_fault                one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       RegWriteM,
  input  logic [4:0] rdM,
  input  logic       RegWriteW,
  input  logic [4:0] rdW,
  input  logic       MemReqM,
  input  logic       dmem_ready,
  output logic       dmem_valid,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mem_fault
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lw_stalls,
  output logic [PERF_W-1:0] perf_flushes,
  output logic [PERF_W-1:0] perf_mem_wait
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             WDOG_EN  = (MEM_TIMEOUT > 0);

  if (MEM_TIMEOUT < 0 || PERF_W < 1) begin : g_bad_params
    $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be >= 0 and PERF_W >= 1");
  end

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             lw_stall;
  logic             mem_stall;
  logic             req_valid;
  logic             wdog_expire;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  hazard_fwd_unit u_fwd_a (
    .rs_e        (Rs1E),
    .reg_write_m (RegWriteM),
    .rd_m        (rdM),
    .reg_write_w (RegWriteW),
    .rd_w        (rdW),
    .fwd_sel     (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_e        (Rs2E),
    .reg_write_m (RegWriteM),
    .rd_m        (rdM),
    .reg_write_w (RegWriteW),
    .rd_w        (rdW),
    .fwd_sel     (fwd_b)
  );

  // Load-use hazard: Decode needs the register a load in Execute is fetching.
  always_comb begin
    lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Watchdog fires on the last allowed WAIT cycle unless memory answers in it.
  always_comb begin
    wdog_expire = WDOG_EN && (state == MEM_WAIT) && (wait_cnt == CNT_LAST) && !dmem_ready;
  end

  // Memory handshake FSM: stall decode, request valid and next state.
  always_comb begin
    mem_stall  = 1'b0;
    req_valid  = 1'b0;
    state_next = MEM_IDLE;
    case (state)
      MEM_IDLE: begin
        // A zero-wait access (ready in the request cycle) never enters WAIT.
        mem_stall  = MemReqM && !dmem_ready;
        req_valid  = MemReqM;
        state_next = (MemReqM && !dmem_ready) ? MEM_WAIT : MEM_IDLE;
      end
      MEM_WAIT: begin
        // On expiry the pipeline is released so the faulting access retires.
        mem_stall  = !dmem_ready && !wdog_expire;
        req_valid  = 1'b1;
        state_next = (dmem_ready || wdog_expire) ? MEM_IDLE : MEM_WAIT;
      end
      default: begin
        mem_stall  = 1'b0;
        req_valid  = 1'b0;
        state_next = MEM_IDLE;
      end
    endcase
  end

  // FSM state and wait counter; the counter sits at zero while idle, which
  // clears it on entry to WAIT, and it saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MEM_IDLE;
      wait_cnt <= {CNT_W{1'b0}};
    end else begin
      state <= state_next;
      if (state == MEM_IDLE) begin
        wait_cnt <= {CNT_W{1'b0}};
      end else if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_ONE;
      end else begin
        wait_cnt <= wait_cnt;
      end
    end
  end

  // Output drive. A memory stall freezes everything and suppresses D/E flushes
  // so a pending branch or load-use takes effect once memory releases.
  always_comb begin
    dmem_valid = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b1;
    FlushE     = 1'b1;
    FlushW     = 1'b1;
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    mem_fault  = 1'b0;
    if (reset) begin
      dmem_valid = 1'b0;
      StallF     = 1'b0;
      StallD     = 1'b0;
      StallE     = 1'b0;
      StallM     = 1'b0;
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      FlushW     = 1'b1;
      ForwardAE  = FWD_RF;
      ForwardBE  = FWD_RF;
      mem_fault  = 1'b0;
    end else begin
      dmem_valid = req_valid;
      StallF     = lw_stall || mem_stall;
      StallD     = lw_stall || mem_stall;
      StallE     = mem_stall;
      StallM     = mem_stall;
      FlushD     = PCSrcE && !mem_stall;
      FlushE     = (lw_stall || PCSrcE) && !mem_stall;
      FlushW     = mem_stall;
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
      mem_fault  = wdog_expire;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lw_stalls <= {PERF_W{1'b0}};
      perf_flushes   <= {PERF_W{1'b0}};
      perf_mem_wait  <= {PERF_W{1'b0}};
    end else begin
      if (lw_stall && !mem_stall && (perf_lw_stalls != PERF_MAX)) begin
        perf_lw_stalls <= perf_lw_stalls + PERF_ONE;
      end else begin
        perf_lw_stalls <= perf_lw_stalls;
      end
      if (PCSrcE && !mem_stall && (perf_flushes != PERF_MAX)) begin
        perf_flushes <= perf_flushes + PERF_ONE;
      end else begin
        perf_flushes <= perf_flushes;
      end
      if (mem_stall && (perf_mem_wait != PERF_MAX)) begin
        perf_mem_wait <= perf_mem_wait + PERF_ONE;
      end else begin
        perf_mem_wait <= perf_mem_wait;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed stimulus with a scoreboard: the driver pushes the hand-computed
// expected output vector for each driven cycle; a monitor on the falling
// edge pops and compares it against the DUT outputs.
// Vector order: {dmem_valid, StallF, StallD, StallE, StallM,
//                FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_fault}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, rdM, rdW;
  logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  logic       dmem_valid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_fault;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [3:0] perf_lw_stalls, perf_flushes, perf_mem_wait;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .PERF_W(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .rdM(rdM), .RegWriteW(RegWriteW), .rdW(rdW),
    .MemReqM(MemReqM), .dmem_ready(dmem_ready), .dmem_valid(dmem_valid),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_fault(mem_fault)
`ifdef HAZARD_PERF_EN
    , .perf_lw_stalls(perf_lw_stalls), .perf_flushes(perf_flushes),
    .perf_mem_wait(perf_mem_wait)
`endif
  );

  logic [12:0] act;
  assign act = {dmem_valid, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_fault};

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          perf_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [12:0] mon_exp;
  string       mon_name;
  int          mon_perf;

  // Monitor: one comparison per queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_checks++;
      if (act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (dv sF sD sE sM fD fE fW fA fB mf)",
                 mon_name, act, mon_exp);
      end
    end
`ifdef HAZARD_PERF_EN
    if (perf_q.size() > 0) begin
      mon_perf = perf_q.pop_front();
      n_checks++;
      if (perf_mem_wait !== 4'(mon_perf)) begin
        n_fail++;
        $display("FAIL perf_mem_wait: got %0d want %0d", perf_mem_wait, mon_perf);
      end
    end
`endif
  end

  function automatic logic [12:0] v(input logic dv, input logic sf, input logic sd,
                                    input logic se, input logic sm, input logic fd,
                                    input logic fe, input logic fw, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic mf);
    return {dv, sf, sd, se, sm, fd, fe, fw, fa, fb, mf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [12:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic clr();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    rdM = 5'd0; rdW = 5'd0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; dmem_ready = 1'b0;
  endtask

  logic [12:0] z, m, r;

  initial begin
    z = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    m = v(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    r = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    clr();
    reset = 1'b1;

    // Reset overrides every input.
    tick(); RegWriteM = 1'b1; rdM = 5'd5; Rs1E = 5'd5; MemReqM = 1'b1; PCSrcE = 1'b1;
    chk("reset", r);
    tick(); reset = 1'b0; clr(); chk("idle", z);

    // Forwarding.
    tick(); RegWriteM = 1'b1; rdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; rdW = 5'd5;
    chk("fwd_m_over_w", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
    tick(); rdM = 5'd0;
    chk("fwd_w_rdm0", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
    tick(); rdM = 5'd3; Rs1E = 5'd3; Rs2E = 5'd5;
    chk("fwd_split", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0));
    tick(); RegWriteM = 1'b0; rdW = 5'd0;
    chk("fwd_none", z);

    // Load-use: one stall cycle, then forward from W.
    tick(); clr(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    chk("lw_stall", v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
    tick(); ResultSrcE0 = 1'b0; RdE = 5'd0; RegWriteM = 1'b1; rdM = 5'd7;
    chk("lw_bubble", z);
    tick(); clr(); Rs2E = 5'd7; RegWriteW = 1'b1; rdW = 5'd7;
    chk("lw_fwd_w", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
    tick(); clr(); ResultSrcE0 = 1'b1; chk("lw_x0", z);

    // Branch.
    tick(); clr(); PCSrcE = 1'b1;
    chk("branch", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));

    // Memory wait of 3 cycles with a branch held during the wait.
    tick(); clr(); MemReqM = 1'b1; chk("mem_busy", m);
    tick(); PCSrcE = 1'b1; chk("mem_wait1", m);
    tick(); chk("mem_wait2", m);
    tick(); dmem_ready = 1'b1;
    chk("mem_release", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
    tick(); clr(); chk("mem_idle", z);
    tick(); MemReqM = 1'b1; dmem_ready = 1'b1;
    chk("mem_zero_wait", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    tick(); clr(); chk("mem_zero_after", z);

    // Watchdog: fault on the 4th WAIT cycle; load-use gated during the wait.
    tick(); MemReqM = 1'b1; chk("wd_busy", m);
    tick(); chk("wd_wait0", m);
    tick(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; chk("wd_wait1_lw_gated", m);
    tick(); ResultSrcE0 = 1'b0; RdE = 5'd0; Rs2D = 5'd0; chk("wd_wait2", m);
    tick();
    chk("wd_fault", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
    tick(); clr(); chk("wd_after", z);

    // Reset in the middle of a wait: straight to IDLE, no fault later.
    tick(); MemReqM = 1'b1; chk("rst_busy", m);
    tick(); chk("rst_wait0", m);
    tick(); reset = 1'b1; chk("rst_mid_wait", r);
    tick(); MemReqM = 1'b0; chk("rst_hold", r);
    tick(); reset = 1'b0; chk("rst_release", z);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("rst_no_fault", z);
    end

`ifdef HAZARD_PERF_EN
    // perf_mem_wait saturates at 15 with PERF_W=4.
    tick(); perf_q.push_back(0);
    tick(); MemReqM = 1'b1;
    repeat (19) tick();
    tick(); clr(); perf_q.push_back(15);
`endif

    tick(); tick();
    for (int i = 0; i < 10 && (exp_q.size() > 0 || perf_q.size() > 0); i++) begin
      tick();
    end
    if (exp_q.size() > 0 || perf_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size() + perf_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
